// File: rtl/bit_word_reader.sv
// rtl/bit_word_reader.sv - assembles 1-bit FIFO stream into WIDTH-bit words.
// Optional even-parity bit per word under macro BIT_WORD_READER_PARITY_EN.
module bit_word_reader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fq,
    input  logic             fvalid,
    output logic             frd,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             drd,
    output logic             perr
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] COLLECT = 2'd0;
`ifdef BIT_WORD_READER_PARITY_EN
    localparam logic [1:0] PARITY  = 2'd1;
`endif
    localparam logic [1:0] STALL   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] held;
    logic [CW-1:0]    cnt;
    logic             held_perr;
    logic             perr_r;
    logic             accept;
    logic             last_data;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    // Popping is blocked in reset, while flushing, and while a finished word waits in STALL.
    assign frd      = fvalid & ~clr & (state != STALL) & ~rst;
    assign accept   = frd;
    assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], fq} : {fq, sr[WIDTH-1:1]};
    assign last_data = (cnt == CW'(WIDTH - 1));
    assign perr     = perr_r;

`ifdef BIT_WORD_READER_PARITY_EN
    assign complete  = accept & (state == PARITY);
    assign word      = sr;
    assign word_perr = (^sr) ^ fq;
`else
    assign complete  = accept & (state == COLLECT) & last_data;
    assign word      = sr_shift;
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            sr        <= '0;
            cnt       <= '0;
            held      <= '0;
            held_perr <= 1'b0;
            dout      <= '0;
            dvalid    <= 1'b0;
            perr_r    <= 1'b0;
        end else if (clr) begin
            // Flush discards the partial and any stalled word; the output register is untouched.
            sr    <= '0;
            cnt   <= '0;
            state <= COLLECT;
            if (drd) begin
                dvalid <= 1'b0;
            end
        end else if (state == STALL) begin
            if (drd) begin
                dout   <= held;
                perr_r <= held_perr;
                state  <= COLLECT;
            end
        end else begin
            if (drd) begin
                dvalid <= 1'b0;
            end
            if (complete) begin
                sr  <= '0;
                cnt <= '0;
                if (!dvalid || drd) begin
                    dout   <= word;
                    perr_r <= word_perr;
                    dvalid <= 1'b1;
                    state  <= COLLECT;
                end else begin
                    held      <= word;
                    held_perr <= word_perr;
                    state     <= STALL;
                end
            end else if (accept) begin
                sr <= sr_shift;
`ifdef BIT_WORD_READER_PARITY_EN
                if (last_data) begin
                    cnt   <= '0;
                    state <= PARITY;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`else
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bit_word_reader.sv
// tb/tb_bit_word_reader.sv - scoreboard bench for bit_word_reader, LSB- and MSB-first instances.
// Honours BIT_WORD_READER_PARITY_EN to append and check the parity bit.
module tb_bit_word_reader;

    localparam int W = 8;
`ifdef BIT_WORD_READER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0, rst = 1'b0, fq = 1'b0, fvalid = 1'b0, clr = 1'b0, drd = 1'b0;
    logic frd_a, frd_b, dvalid_a, dvalid_b, perr_a, perr_b;
    logic [W-1:0] dout_a, dout_b;

    always #5 clk = ~clk;

    bit_word_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .fq(fq), .fvalid(fvalid), .frd(frd_a), .clr(clr),
        .dout(dout_a), .dvalid(dvalid_a), .drd(drd), .perr(perr_a)
    );

    bit_word_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .fq(fq), .fvalid(fvalid), .frd(frd_b), .clr(clr),
        .dout(dout_b), .dvalid(dvalid_b), .drd(drd), .perr(perr_b)
    );

    typedef struct {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   bits[$];
    int   occ = 0;          // words delivered by the reader but not yet taken (0..2)
    logic exp_frd = 1'b0;
    logic exp_dvalid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp(input bit msbf);
        exp_t e;
        e.word = '0;
        e.perr = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bits[i]) e.word[msbf ? W - 1 - i : i] = 1'b1;
        end
`ifdef BIT_WORD_READER_PARITY_EN
        for (int i = 0; i < NB; i++) e.perr = e.perr ^ bits[i];
`endif
        return e;
    endfunction

    task automatic model_edge(input logic v, input logic b, input logic c, input logic d);
        bit acc;
        bit take;
        acc  = v && !c && (occ < 2);
        take = d && (occ > 0);
        if (c) begin
            bits.delete();
            if (occ == 2) begin
                q_a.delete(q_a.size() - 1);
                q_b.delete(q_b.size() - 1);
                occ = 1;
            end
            if (take) occ--;
        end else begin
            if (take) occ--;
            if (acc) begin
                bits.push_back(b);
                if (bits.size() == NB) begin
                    q_a.push_back(make_exp(1'b0));
                    q_b.push_back(make_exp(1'b1));
                    bits.delete();
                    occ++;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic c, input logic d);
        fvalid = v;
        fq     = b;
        clr    = c;
        drd    = d;
        exp_frd    = v & ~c & (occ < 2);
        exp_dvalid = (occ > 0);
        @(posedge clk);
        model_edge(v, b, c, d);
        #1;
    endtask

    task automatic do_reset();
        fvalid = 1'b1;
        rst = 1'b1;
        bits.delete();
        q_a.delete();
        q_b.delete();
        occ = 0;
        #1;
        check("rst_frd", frd_a | frd_b, 0);
        check("rst_dvalid", dvalid_a | dvalid_b, 0);
        check("rst_dout_a", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_perr", perr_a | perr_b, 0);
        @(posedge clk);
        #1;
        fvalid = 1'b0;
        clr = 1'b0;
        drd = 1'b0;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap_max, input logic d);
        for (int i = 0; i < W; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, d);
            end
            drive(1'b1, w[i], 1'b0, d);
        end
`ifdef BIT_WORD_READER_PARITY_EN
        drive(1'b1, ^w, 1'b0, d);
`endif
    endtask

    // Monitor: every presented word that the consumer takes is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("frd_a", frd_a, exp_frd);
            check("frd_b", frd_b, exp_frd);
            check("dvalid_a", dvalid_a, exp_dvalid);
            check("dvalid_b", dvalid_b, exp_dvalid);
            if (dvalid_a && drd) begin
                if (q_a.size() == 0) check("underflow_a", 1, 0);
                else begin
                    e = q_a.pop_front();
                    check("dout_a", dout_a, e.word);
                    check("perr_a", perr_a, e.perr);
                end
            end
            if (dvalid_b && drd) begin
                if (q_b.size() == 0) check("underflow_b", 1, 0);
                else begin
                    e = q_b.pop_front();
                    check("dout_b", dout_b, e.word);
                    check("perr_b", perr_b, e.perr);
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        send_word(8'h0D, 0, 1'b0);
        check("lsb_0d", dout_a, 8'h0D);
        check("msb_b0", dout_b, 8'hB0);
        check("latency_dvalid", dvalid_a, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'h0D, 3, 1'b0);
        check("gap_msb_b0", dout_b, 8'hB0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'h35, 0, 1'b0);
        send_word(8'hCA, 0, 1'b0);
        check("stall_first", dout_a, 8'h35);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("stall_second", dout_a, 8'hCA);
        check("stall_dvalid", dvalid_a, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_drd_dvalid", dvalid_a, 0);

        send_word(8'h5A, 0, 1'b0);
        repeat (5) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_keeps_dvalid", dvalid_a, 1);
        check("clr_keeps_dout", dout_a, 8'h5A);
        send_word(8'hFF, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("after_clr_ff", dout_a, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_word(8'h96, 1, 1'b0);
        check("fresh_lsb", dout_a, 8'h96);
        check("fresh_msb", dout_b, 8'h69);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) send_word(8'($urandom), 0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BIT_WORD_READER_PARITY_EN
        for (int i = 0; i < W; i++) drive(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("parity_bad", perr_a, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) drive(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("parity_good", perr_a, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        for (int blk = 0; blk < 20; blk++) begin
            int drd_pct;
            drd_pct = $urandom_range(0, 100);
            repeat (200) begin
                drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 59) == 0, $urandom_range(0, 99) < drd_pct);
            end
        end

        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_word_reader.md
BIT_WORD_READER -- requirements
Module: bit_word_reader

Interface
REQ-001 Parameter WIDTH, default 8, sets the word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 means the first bit read is DOUT[0]; 1 means the first bit read is DOUT[WIDTH-1].
REQ-003 CLK  in  1  single clock; every register changes on its rising edge.
REQ-004 RST  in  1  asynchronous reset, active-high.
REQ-005 FQ  in  1  head bit of the upstream 1-bit FIFO.
REQ-006 FVALID  in  1  upstream FIFO head is valid.
REQ-007 FRD  out  1  pops the upstream FIFO head; combinational.
REQ-008 CLR  in  1  synchronous flush of the partial word.
REQ-009 DOUT  out  WIDTH  assembled word.
REQ-010 DVALID  out  1  DOUT holds an unconsumed word.
REQ-011 DRD  in  1  consumer takes DOUT this cycle.
REQ-012 PERR  out  1  parity error flag qualified by DVALID; tied 0 without the macro.

Function
REQ-013 The block SHALL use a state machine with states COLLECT, PARITY (macro only) and STALL.
REQ-014 FRD SHALL equal FVALID & ~CLR & (state != STALL); a bit is accepted when FRD=1.
REQ-015 On each accepted bit in COLLECT, the block SHALL shift FQ into shift register SR in MSB_FIRST order and increment bit counter CNT (0..WIDTH-1).
REQ-016 While FVALID=0, SR, CNT and state SHALL hold; gaps of any length are legal.
REQ-017 The word SHALL complete on the bit accepted with CNT=WIDTH-1, or on the parity bit when the macro is defined.
REQ-018 On word completion with DVALID=0 or DRD=1 in the same cycle, the block SHALL load DOUT, set DVALID=1, clear CNT and stay in or return to COLLECT.
REQ-019 Latency: when the completing bit is accepted in cycle N, DVALID SHALL be high in cycle N+1.
REQ-020 On word completion with DVALID=1 and DRD=0, the block SHALL enter STALL holding the assembled word, with FRD=0.
REQ-021 In STALL with DRD=1, the block SHALL load DOUT from the held word, keep DVALID=1 and return to COLLECT in the next cycle.
REQ-022 DRD with DVALID=1 and no word loaded in the same cycle SHALL clear DVALID.
REQ-023 DRD with DVALID=0 SHALL be ignored.
REQ-024 CLR SHALL clear CNT and SR and return the state to COLLECT (discarding any STALL word), and SHALL leave DOUT and DVALID unchanged.
REQ-025 CLR asserted together with DRD SHALL still honour DRD for DVALID.
REQ-026 Back-to-back words with DRD held high SHALL sustain one bit accepted per cycle with no bubbles.

Reset
REQ-027 RST=1 SHALL immediately force DOUT=0, DVALID=0, PERR=0, SR=0, CNT=0 and state=COLLECT; FRD SHALL be 0 while RST=1.
REQ-028 RST asserted mid-word or in STALL SHALL discard all partial and held data; the first bit accepted after release SHALL be bit 0 of a new word.

Configuration
REQ-029 Macro BIT_WORD_READER_PARITY_EN: when defined, after the WIDTH data bits the block SHALL accept one extra bit in state PARITY (even parity), and PERR SHALL be loaded with DOUT as XOR(data bits) ^ parity bit.
REQ-030 Without BIT_WORD_READER_PARITY_EN: the PARITY state SHALL be absent, words SHALL be exactly WIDTH bits, and PERR SHALL be constant 0.

Verification
REQ-031 WIDTH=8, MSB_FIRST=0, bits 1,0,1,1,0,0,0,0 on consecutive cycles -> DOUT=0x0D, DVALID=1 one cycle after the 8th bit.
REQ-032 MSB_FIRST=1, same bits with random FVALID gaps -> DOUT=0xB0, with the gap count not affecting the result.
REQ-033 Two words streamed with DRD=0 -> first word on DOUT, FRD=0 after the 16th bit (STALL); pulse DRD -> DOUT=second word, DVALID stays 1, FRD resumes the next cycle.
REQ-034 CLR after 5 bits, then 8 bits 0xFF -> DOUT=0xFF; the earlier 5 bits are discarded; a pending DVALID is preserved across CLR.
REQ-035 RST pulse in STALL -> DVALID=0, DOUT=0 immediately; the next 8 bits form a fresh word.
REQ-036 With the macro defined, data 0x07 plus parity bit 0 -> PERR=1; data 0x07 plus parity bit 1 -> PERR=0.
